staged_mult: RTL

- Pipelined unsigned multiplier; the responder side of the start/done multiply handshake used by the iterative arithmetic blocks (e.g. the integer square-root unit).
- Operands are captured on a `start` pulse. `done` pulses exactly NSTAGE cycles later, with the product valid in the same cycle.
- Fully pipelined: a new operation may start every cycle.

---
 rtl/staged_mult.sv | 112 +++++++++++
 1 files changed

// File: rtl/staged_mult.sv
// staged_mult: pipelined unsigned multiplier, responder side of the start/done multiply
// handshake. Operands are captured on a start pulse and the truncated product appears with a
// one-cycle done pulse exactly NSTAGE cycles later. A new operation may start every cycle.
//
// Parameters:
//   TBIT   - operand and product width (must be a multiple of NSTAGE)
//   NSTAGE - pipeline depth; each stage consumes W = TBIT/NSTAGE multiplier bits
//
// Ports:
//   clock   - rising-edge clock
//   reset   - synchronous, active-high reset; discards all in-flight operations
//   start   - operands valid, sampled every rising edge
//   mcand   - multiplicand (unsigned)
//   mplier  - multiplier (unsigned)
//   product - low TBIT bits of mcand*mplier, meaningful only while done=1
//   done    - one-cycle pulse marking product valid
//   ovf     - (only with STAGED_MULT_OVF_EN) full product exceeds TBIT bits; 0 unless done
//
// Optional feature macro: STAGED_MULT_OVF_EN widens the accumulator and shifted multiplicand
// to 2*TBIT and adds the ovf output.

module staged_mult #(
    parameter int unsigned TBIT   = 64,
    parameter int unsigned NSTAGE = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [TBIT-1:0] mcand,
    input  logic [TBIT-1:0] mplier,
`ifdef STAGED_MULT_OVF_EN
    output logic            ovf,
`endif
    output logic [TBIT-1:0] product,
    output logic            done
);

    localparam int unsigned W = TBIT / NSTAGE;
`ifdef STAGED_MULT_OVF_EN
    localparam int unsigned AW = 2 * TBIT;
`else
    localparam int unsigned AW = TBIT;
`endif

    if (NSTAGE < 1 || NSTAGE > TBIT || (TBIT % NSTAGE) != 0) begin : g_bad_params
        $error("staged_mult: TBIT must be a nonzero multiple of NSTAGE");
    end

    // Per-stage state: valid flag, partial-product accumulator, multiplicand pre-shifted to the
    // weight of the next multiplier slice, and the multiplier bits still to be consumed.
    logic [NSTAGE-1:0] valid_q, valid_d;
    logic [AW-1:0]     acc_q [NSTAGE];
    logic [AW-1:0]     acc_d [NSTAGE];
    logic [AW-1:0]     mc_q  [NSTAGE];
    logic [AW-1:0]     mc_d  [NSTAGE];
    logic [TBIT-1:0]   mp_q  [NSTAGE];
    logic [TBIT-1:0]   mp_d  [NSTAGE];

    always_comb begin
        valid_d = valid_q;
        for (int unsigned k = 0; k < NSTAGE; k++) begin
            acc_d[k] = acc_q[k];
            mc_d[k]  = mc_q[k];
            mp_d[k]  = mp_q[k];
        end

        // Stage 0 data only loads on start; with start=0 it keeps stale data but valid drops.
        valid_d[0] = start;
        if (start) begin
            acc_d[0] = AW'(mcand) * AW'(mplier[W-1:0]);
            mc_d[0]  = AW'(mcand) << W;
            mp_d[0]  = mplier >> W;
        end

        for (int unsigned k = 1; k < NSTAGE; k++) begin
            valid_d[k] = valid_q[k-1];
            acc_d[k]   = acc_q[k-1] + mc_q[k-1] * AW'(mp_q[k-1][W-1:0]);
            mc_d[k]    = mc_q[k-1] << W;
            mp_d[k]    = mp_q[k-1] >> W;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            for (int unsigned k = 0; k < NSTAGE; k++) begin
                acc_q[k] <= '0;
                mc_q[k]  <= '0;
                mp_q[k]  <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int unsigned k = 0; k < NSTAGE; k++) begin
                acc_q[k] <= acc_d[k];
                mc_q[k]  <= mc_d[k];
                mp_q[k]  <= mp_d[k];
            end
        end
    end

    // The last stage's shifted operands have no consumer.
    logic unused_tail;
    assign unused_tail = ^{mc_q[NSTAGE-1], mp_q[NSTAGE-1]};

    assign product = acc_q[NSTAGE-1][TBIT-1:0];
    assign done    = valid_q[NSTAGE-1];

`ifdef STAGED_MULT_OVF_EN
    assign ovf = valid_q[NSTAGE-1] & (|acc_q[NSTAGE-1][AW-1:TBIT]);
`endif

endmodule
